// File: rtl/mem_io_responder.sv
// mem_io_responder: target end of the byte-serial CPU memory bus.
// Serves a byte-addressed RAM plus an IO window (0x3xxxx) holding a TX FIFO
// (CPU->host) and an RX FIFO (host->CPU). Read data lags the address by one cycle.
module mem_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_AW    = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        io_buffer_full
);

  localparam int FIFO_DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   CNT_FULL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   CNT_ZERO = '0;
  localparam logic [FIFO_AW:0]   CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};

  // Address bits above the decoded range carry no meaning on this bus.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_a[31:18];

  // Storage
  logic [7:0] ram_mem [1 << ADDR_WIDTH];
  logic [7:0] tx_mem  [FIFO_DEPTH];
  logic [7:0] rx_mem  [FIFO_DEPTH];

  // Registered state
  logic [7:0]         ram_rd_q;
  logic [7:0]         io_rd_q, io_rd_d;
  logic               sel_ram_q, sel_ram_d;
  logic               overflow_q, overflow_d;
  logic [FIFO_AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [FIFO_AW:0]   tx_count_q, tx_count_d;
  logic [FIFO_AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [FIFO_AW:0]   rx_count_q, rx_count_d;

  // Decode and handshake strobes
  logic                  io_win, io_data_hit, io_stat_hit, ram_we;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic                  tx_push, tx_pop, rx_push, rx_pop;

  // Address decode and FIFO flags from pre-edge counts
  always_comb begin
    io_win      = (mem_a[17:16] == 2'b11);
    io_data_hit = (mem_a[17:0] == 18'h30000);
    io_stat_hit = (mem_a[17:0] == 18'h30004);
    ram_idx     = mem_a[ADDR_WIDTH-1:0];
    ram_we      = mem_wr & ~io_win;
    tx_full     = (tx_count_q == CNT_FULL);
    tx_empty    = (tx_count_q == CNT_ZERO);
    rx_full     = (rx_count_q == CNT_FULL);
    rx_empty    = (rx_count_q == CNT_ZERO);
    // A push into a full FIFO is dropped even if the same edge pops.
    tx_push     = io_data_hit & mem_wr & ~tx_full;
    tx_pop      = ~tx_empty & tx_ready;
    rx_push     = rx_valid & ~rx_full;
    rx_pop      = io_data_hit & ~mem_wr & ~rx_empty;
  end

  // Host-side outputs; tx_data is forced to zero while the FIFO is empty
  always_comb begin
    tx_valid       = ~tx_empty;
    tx_data        = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr_q];
    io_buffer_full = tx_full;
    rx_ready       = ~rx_full;
  end

  // Next-state: read-data source, IO read byte, overflow flag, FIFO pointers and counts
  always_comb begin
    sel_ram_d   = ~mem_wr & ~io_win;
    io_rd_d     = 8'h00;
    overflow_d  = overflow_q;
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_count_d  = tx_count_q;
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_count_d  = rx_count_q;

    if (!mem_wr && io_data_hit && !rx_empty) begin
      io_rd_d = rx_mem[rx_rd_ptr_q];
    end else if (!mem_wr && io_stat_hit) begin
      io_rd_d = {5'b0, overflow_q, ~rx_empty, tx_full};
    end

    if (mem_wr && io_stat_hit) begin
      overflow_d = 1'b0;
    end else if (mem_wr && io_data_hit && tx_full) begin
      overflow_d = 1'b1;
    end

    if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + PTR_ONE;
    if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + PTR_ONE;
    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + CNT_ONE;
      2'b01:   tx_count_d = tx_count_q - CNT_ONE;
      default: tx_count_d = tx_count_q;
    endcase

    if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + PTR_ONE;
    if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + PTR_ONE;
    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + CNT_ONE;
      2'b01:   rx_count_d = rx_count_q - CNT_ONE;
      default: rx_count_d = rx_count_q;
    endcase
  end

  // Control state register; reset clears FIFOs and any in-flight read
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      io_rd_q     <= 8'h00;
      sel_ram_q   <= 1'b0;
      overflow_q  <= 1'b0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
    end else begin
      io_rd_q     <= io_rd_d;
      sel_ram_q   <= sel_ram_d;
      overflow_q  <= overflow_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_count_q  <= tx_count_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_count_q  <= rx_count_d;
    end
  end

  // RAM with registered read; contents are deliberately not reset
  always_ff @(posedge clk_in) begin
    if (ram_we) ram_mem[ram_idx] <= mem_dout;
    ram_rd_q <= ram_mem[ram_idx];
  end

  // FIFO storage writes
  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= mem_dout;
    if (rx_push) rx_mem[rx_wr_ptr_q] <= rx_data;
  end

  // Read data: RAM byte for RAM reads, otherwise the IO byte (0 for writes)
  always_comb begin
    mem_din = sel_ram_q ? ram_rd_q : io_rd_q;
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: stimulus pushes expected bytes,
// independent monitors compare mem_din responses and TX host handshakes.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] mem_a = '0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_dout = '0;
  logic [7:0]  mem_din;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready;
  logic        io_buffer_full;

  mem_io_responder #(.ADDR_WIDTH(17), .FIFO_AW(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_wr(mem_wr),
    .mem_dout(mem_dout), .mem_din(mem_din), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    string      nm;
    logic [7:0] v;
  } exp_t;

  exp_t       rd_q[$];
  logic [7:0] tx_q[$];
  int         errors = 0;
  int         checks = 0;
  logic       chk_now = 1'b0;
  int         tx_seen = 0;

  localparam logic [31:0] IO_DATA = 32'h30000;
  localparam logic [31:0] IO_STAT = 32'h30004;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  // One bus access; when chk is set the expected mem_din is queued for the monitor
  task automatic acc(input logic [31:0] a, input logic w, input logic [7:0] d,
                     input logic chk, input logic [7:0] e, input string nm);
    exp_t x;
    mem_a = a; mem_wr = w; mem_dout = d; chk_now = chk;
    if (chk) begin
      x.nm = nm; x.v = e;
      rd_q.push_back(x);
    end
    @(posedge clk_in); #1;
    chk_now = 1'b0; mem_a = '0; mem_wr = 1'b0; mem_dout = '0;
  endtask

  task automatic host_push(input logic [7:0] d);
    rx_valid = 1'b1; rx_data = d;
    @(posedge clk_in); #1;
    rx_valid = 1'b0; rx_data = '0;
  endtask

  // mem_din monitor: an access flagged at an edge is compared mid-next-cycle
  initial begin
    logic pend;
    exp_t x;
    forever begin
      @(posedge clk_in);
      pend = chk_now;
      @(negedge clk_in);
      if (pend) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd_underrun: mem_din=%02h with no expected entry", mem_din);
        end else begin
          x = rd_q.pop_front();
          if (mem_din !== x.v) begin
            errors++;
            $display("FAIL %s: mem_din=%02h expected %02h", x.nm, mem_din, x.v);
          end else begin
            $display("rd   %s: mem_din=%02h", x.nm, mem_din);
          end
        end
      end
    end
  end

  // TX host monitor: every handshake must deliver the next queued byte
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk_in);
      if (!rst_in && tx_valid && tx_ready) begin
        checks++;
        tx_seen++;
        if (tx_q.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: tx_data=%02h with no expected byte", tx_data);
        end else begin
          e = tx_q.pop_front();
          if (tx_data !== e) begin
            errors++;
            $display("FAIL tx_byte: tx_data=%02h expected %02h", tx_data, e);
          end else begin
            $display("tx   host got %02h", tx_data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset
    @(posedge clk_in); #2;
    check("rst_mem_din", mem_din, 8'h00);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_rx_ready", rx_ready, 1'b1);
    check("rst_full", io_buffer_full, 1'b0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;

    // RAM write then read, and zero read data on a write
    acc(32'h10, 1'b1, 8'hA5, 1'b1, 8'h00, "ram_wr_din0");
    acc(32'h10, 1'b0, 8'h00, 1'b1, 8'hA5, "ram_rd_10");
    acc(32'h0, 1'b1, 8'h5C, 1'b0, 8'h00, "");
    acc(32'h0, 1'b0, 8'h00, 1'b1, 8'h5C, "ram_rd_0");

    // Controller-style word write then back-to-back reads
    for (int i = 0; i < 4; i++) acc(32'h100 + i, 1'b1, 8'h11 * (i + 1), 1'b0, 8'h00, "");
    acc(32'h100, 1'b0, 8'h00, 1'b1, 8'h11, "word_b0");
    acc(32'h101, 1'b0, 8'h00, 1'b1, 8'h22, "word_b1");
    acc(32'h102, 1'b0, 8'h00, 1'b1, 8'h33, "word_b2");
    acc(32'h103, 1'b0, 8'h00, 1'b1, 8'h44, "word_b3");

    // TX fill, overflow, status, drain
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      acc(IO_DATA, 1'b1, 8'h41 + i[7:0], 1'b0, 8'h00, "");
      if (i < 8) tx_q.push_back(8'h41 + i[7:0]);
      if (i == 6) check("tx_full_after7", io_buffer_full, 1'b0);
      if (i == 7) check("tx_full_after8", io_buffer_full, 1'b1);
    end
    acc(IO_STAT, 1'b0, 8'h00, 1'b1, 8'h05, "stat_tx_ovf");
    acc(32'h30008, 1'b1, 8'h99, 1'b0, 8'h00, "");
    acc(32'h30008, 1'b0, 8'h00, 1'b1, 8'h00, "io_unmapped");
    tx_ready = 1'b1;
    n = 0;
    while (tx_valid && n < 40) begin
      @(posedge clk_in); #1;
      n++;
    end
    tx_ready = 1'b0;
    check("tx_drained", tx_valid, 1'b0);
    check("tx_count_recv", tx_seen, 8);
    check("tx_q_empty", tx_q.size(), 0);
    acc(IO_STAT, 1'b1, 8'hFF, 1'b0, 8'h00, "");
    acc(IO_STAT, 1'b0, 8'h00, 1'b1, 8'h00, "stat_cleared");

    // RX path
    host_push(8'h10);
    host_push(8'h20);
    acc(IO_STAT, 1'b0, 8'h00, 1'b1, 8'h02, "stat_rx");
    acc(IO_DATA, 1'b0, 8'h00, 1'b1, 8'h10, "rx_rd0");
    acc(IO_DATA, 1'b0, 8'h00, 1'b1, 8'h20, "rx_rd1");
    acc(IO_DATA, 1'b0, 8'h00, 1'b1, 8'h00, "rx_rd_empty");
    acc(IO_STAT, 1'b0, 8'h00, 1'b1, 8'h00, "stat_rx_empty");

    // Simultaneous host push and CPU pop with 3 bytes held
    host_push(8'hA1);
    host_push(8'hA2);
    host_push(8'hA3);
    rx_valid = 1'b1; rx_data = 8'hA4;
    acc(IO_DATA, 1'b0, 8'h00, 1'b1, 8'hA1, "sim_rd0");
    rx_valid = 1'b0; rx_data = '0;
    acc(IO_DATA, 1'b0, 8'h00, 1'b1, 8'hA2, "sim_rd1");
    acc(IO_DATA, 1'b0, 8'h00, 1'b1, 8'hA3, "sim_rd2");
    acc(IO_DATA, 1'b0, 8'h00, 1'b1, 8'hA4, "sim_rd3");
    acc(IO_DATA, 1'b0, 8'h00, 1'b1, 8'h00, "sim_empty");

    // RX full: offered byte must not be captured
    for (int i = 0; i < 8; i++) host_push(8'hB0 + i[7:0]);
    check("rx_full_ready", rx_ready, 1'b0);
    host_push(8'hEE);
    check("rx_full_ready2", rx_ready, 1'b0);
    for (int i = 0; i < 8; i++) acc(IO_DATA, 1'b0, 8'h00, 1'b1, 8'hB0 + i[7:0], "rx_full_rd");
    acc(IO_DATA, 1'b0, 8'h00, 1'b1, 8'h00, "rx_full_dropped");
    check("rx_ready_again", rx_ready, 1'b1);

    // Async reset mid-burst with TX holding 4 bytes and mem_din non-zero
    for (int i = 0; i < 4; i++) acc(IO_DATA, 1'b1, 8'h61 + i[7:0], 1'b0, 8'h00, "");
    host_push(8'h77);
    acc(32'h10, 1'b0, 8'h00, 1'b1, 8'hA5, "pre_rst_rd");
    @(negedge clk_in); #1;
    check("pre_rst_tx_valid", tx_valid, 1'b1);
    rst_in = 1'b1;
    #1;
    check("arst_tx_valid", tx_valid, 1'b0);
    check("arst_rx_ready", rx_ready, 1'b1);
    check("arst_mem_din", mem_din, 8'h00);
    check("arst_tx_data", tx_data, 8'h00);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    check("post_rst_tx_valid", tx_valid, 1'b0);
    acc(IO_STAT, 1'b0, 8'h00, 1'b1, 8'h00, "post_rst_stat");
    acc(IO_DATA, 1'b0, 8'h00, 1'b1, 8'h00, "post_rst_rx_empty");
    acc(IO_DATA, 1'b1, 8'h3C, 1'b0, 8'h00, "");
    check("post_rst_tx_one", tx_valid, 1'b1);
    check("post_rst_tx_data", tx_data, 8'h3C);

    repeat (3) @(posedge clk_in);
    #1;
    check("rd_q_drained", rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Target end of the byte-serial memory bus driven by the CPU memory controller (mem_a / mem_wr / mem_dout out, mem_din back).
- Serves a byte-addressed RAM plus a small memory-mapped IO window.
- The IO window contains a TX FIFO (CPU→host) and an RX FIFO (host→CPU), each with valid/ready handshakes on the host side.
- Read data returns one cycle after the address, matching the controller's "issue next address, sample previous byte" pipeline.

Parameters:
- ADDR_WIDTH, 17, RAM byte-address width (RAM = 2^ADDR_WIDTH bytes, index mem_a[ADDR_WIDTH-1:0]).
- FIFO_AW, 3, log2 depth of each IO FIFO (depth 8).

Ports:
- clk_in  input  1  system clock, all state on rising edge
- rst_in  input  1  reset, asynchronous, active-high
- mem_a  input  32  byte address; only [17:0] decoded
- mem_wr  input  1  1 = write mem_dout at mem_a, 0 = read
- mem_dout  input  8  write data from controller
- mem_din  output  8  read data to controller, registered
- tx_valid  output  1  TX FIFO non-empty
- tx_data  output  8  TX FIFO head byte
- tx_ready  input  1  host consumes head when tx_valid && tx_ready
- rx_valid  input  1  host offers rx_data
- rx_data  input  8  host byte
- rx_ready  output  1  RX FIFO not full
- io_buffer_full  output  1  TX FIFO full; CPU top uses it to drop rdy_in

Behaviour:
- Reset (async, rst_in=1):
  - mem_din=0; both FIFOs empty (pointers and counts 0); overflow flag 0.
  - Outputs during and after reset: tx_valid=0, tx_data=0, rx_ready=1, io_buffer_full=0.
  - RAM contents not reset.
  - Reset mid-operation discards FIFO contents and any in-flight read.
- Decode:
  - IO window when mem_a[17:16]==2'b11; otherwise RAM.
  - Registers: IO_DATA=0x30000, IO_STAT=0x30004.
  - Other IO-window addresses read 0x00; writes to them are ignored.
- Every cycle is exactly one access; there is no idle encoding. The controller idles at mem_a=0, mem_wr=0, which is a harmless RAM read of byte 0.
- RAM read (mem_wr=0): mem_din <= ram[mem_a[ADDR_WIDTH-1:0]] at the edge. Valid for the whole following cycle; latency 1.
- RAM write (mem_wr=1): ram[idx] <= mem_dout at the edge; mem_din <= 0x00.
- Read-after-write to the same address on the next cycle returns the new byte; no bypass is needed because the write lands at the edge before the read.
- IO_DATA read:
  - If RX non-empty: mem_din <= RX head and pop.
  - Else: mem_din <= 0x00, no pop.
  - Consecutive-cycle reads pop consecutive bytes.
- IO_DATA write:
  - If TX not full: push mem_dout.
  - Else: drop the byte and set overflow=1 (sticky).
- IO_STAT read: mem_din <= {5'b0, overflow, rx_nonempty, tx_full}, using pre-edge values.
- IO_STAT write: clears overflow; data ignored.
- Full/empty rules: full/empty are from registered counts before the edge.
  - Push into a full FIFO is dropped even if a pop occurs the same edge.
  - Pop from an empty FIFO is a no-op.
  - Simultaneous push+pop on a non-full, non-empty FIFO leaves the count unchanged.
  - Pointers wrap modulo 2^FIFO_AW.
- Host side:
  - tx_valid = (tx_count!=0); tx_data = mem[tx_rd_ptr], combinational from registered state.
  - io_buffer_full = (tx_count==2^FIFO_AW).
  - rx_ready = (rx_count!=2^FIFO_AW); RX push on rx_valid && rx_ready.
  - rx_data is ignored when rx_ready=0.
- Count arithmetic: counts are FIFO_AW+1 bits wide and never exceed depth or go below 0.

Test Plan:
- RAM write/read: write 0xA5 @0x00010, next cycle read 0x00010 → mem_din=0xA5 one cycle later; read @0x00000 after reset → RAM content, no X on mem_din reset value (0x00).
- Word sequence as controller issues it: writes 0x11,0x22,0x33,0x44 @0x100..0x103, then reads in back-to-back cycles → mem_din sequence 0x11,0x22,0x33,0x44 each lagging address by 1 cycle.
- TX path: 9 writes of 0x41+i to 0x30000 with tx_ready=0 → io_buffer_full=1 after 8th, 9th dropped, IO_STAT read = 0x05. Then tx_ready=1 → host receives 0x41..0x48 in order. Then IO_STAT write → read returns 0x00.
- RX path: host pushes 0x10,0x20; IO_STAT read = 0x02; IO_DATA reads return 0x10, 0x20, then 0x00 (empty, no underflow, count stays 0).
- Simultaneous events: RX holding 3 bytes, rx_valid=1 on the same edge as an IO_DATA read → count stays 3, byte order preserved. RX full: rx_ready=0 and offered byte not captured.
- Async reset mid-burst: assert rst_in between edges with TX holding 4 bytes → tx_valid=0, rx_ready=1, mem_din=0 immediately without a clock edge; FIFOs empty after release.
